// File: rtl/rr_dispatch_pkg.sv
// Shared constants and state encoding for the round-robin dispatcher.
package rr_dispatch_pkg;

  localparam int unsigned N_DST = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin grant: first ready destination at or after ptr, wrapping mod 4.
module rr_arbiter4
  import rr_dispatch_pkg::*;
(
  input  logic [N_DST-1:0] dst_ready,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] k
);

  logic [SEL_W-1:0] idx;
  logic             found;

  always_comb begin
    k     = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int i = 0; i < N_DST; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && dst_ready[idx]) begin
        found = 1'b1;
        k     = idx;
      end
    end
  end

  assign any = |dst_ready;

endmodule

// File: rtl/rr_dispatcher4.sv
// One-token round-robin dispatcher driving a 1-to-4 demux select and strobe.
// Optional stall detection is built when RR_DISPATCHER_STALL_EN is defined.
module rr_dispatcher4
  import rr_dispatch_pkg::*;
#(
  parameter int unsigned STALL_MAX = 15,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_DST-1:0] dst_ready,
  output logic [SEL_W-1:0] b1_b0,
  output logic             x0,
  output logic             stall
);

  if (STALL_MAX < 1 || STALL_MAX > (2 ** CNT_W) - 1) begin : g_bad_cfg
    $error("rr_dispatcher4: STALL_MAX must fit in 1..2^CNT_W-1");
  end

  state_e           state_q;
  logic [SEL_W-1:0] ptr_q;
  logic             any;
  logic [SEL_W-1:0] k;
  logic             accept;

  rr_arbiter4 u_arb (
    .dst_ready (dst_ready),
    .ptr       (ptr_q),
    .any       (any),
    .k         (k)
  );

  assign in_ready = (state_q == ST_EMPTY) | any;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      b1_b0   <= '0;
      x0      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          x0 <= 1'b0;
          if (accept) state_q <= ST_PENDING;
        end
        ST_PENDING: begin
          if (any) begin
            b1_b0   <= k;
            x0      <= 1'b1;
            ptr_q   <= k + SEL_W'(1);
            state_q <= accept ? ST_PENDING : ST_EMPTY;
          end else begin
            x0 <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          x0      <= 1'b0;
        end
      endcase
    end
  end

`ifdef RR_DISPATCHER_STALL_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts only cycles where a held token finds no ready destination.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_EMPTY || any) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(STALL_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      stall <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      stall <= (cnt_d == CNT_W'(STALL_MAX));
    end
  end
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_rr_dispatcher4.sv
// Scoreboard bench for rr_dispatcher4: reference model pushes expected selects, monitor pops on x0.
module tb_rr_dispatcher4;

  localparam int unsigned STALL_MAX = 3;
  localparam int unsigned CNT_W     = 4;

  logic       clock     = 1'b0;
  logic       reset     = 1'b1;
  logic       in_valid  = 1'b0;
  logic [3:0] dst_ready = 4'h0;
  logic       in_ready;
  logic [1:0] b1_b0;
  logic       x0;
  logic       stall;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: token held, rotating start index, last select, idle-wait count.
  int exp_q[$];
  int m_full = 0;
  int m_ptr  = 0;
  int m_sel  = 0;
  int m_wait = 0;

  always #5 clock = ~clock;

  rr_dispatcher4 #(
    .STALL_MAX (STALL_MAX),
    .CNT_W     (CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dst_ready (dst_ready),
    .b1_b0     (b1_b0),
    .x0        (x0),
    .stall     (stall)
  );

  function automatic int pick(input logic [3:0] d, input int p);
    for (int i = 0; i < 4; i++) begin
      if (d[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clock) begin
    int acc;
    int g;
    if (reset) begin
      m_full = 0;
      m_ptr  = 0;
      m_sel  = 0;
      m_wait = 0;
    end else begin
      acc = (in_valid && (m_full == 0 || dst_ready != 4'h0)) ? 1 : 0;
      if (m_full != 0 && dst_ready != 4'h0) begin
        g = pick(dst_ready, m_ptr);
        exp_q.push_back(g);
        m_sel  = g;
        m_ptr  = (g + 1) % 4;
        m_wait = 0;
        m_full = acc;
      end else if (m_full != 0) begin
        m_wait++;
      end else begin
        m_full = acc;
        m_wait = 0;
      end
    end
  end

  always @(negedge clock) begin
    int e;
    int exp_stall;
    if (x0 === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_sel", int'(b1_b0), e);
      end
    end else begin
      check("strobe_level", int'(x0 === 1'b0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("missing_strobe", 0, 1);
      end
    end
    check("b1_b0", int'(b1_b0), m_sel);
    check("in_ready", int'(in_ready), (m_full == 0 || dst_ready != 4'h0) ? 1 : 0);
`ifdef RR_DISPATCHER_STALL_EN
    exp_stall = (m_wait >= int'(STALL_MAX)) ? 1 : 0;
`else
    exp_stall = 0;
`endif
    check("stall", int'(stall), exp_stall);
  end

  task automatic drive(input logic r, input logic v, input logic [3:0] d, input int n);
    reset     = r;
    in_valid  = v;
    dst_ready = d;
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  initial begin
    // Reset held with traffic offered.
    drive(1'b1, 1'b1, 4'hF, 2);
    drive(1'b0, 1'b0, 4'hF, 2);
    // Continuous rotation of six tokens.
    drive(1'b0, 1'b1, 4'hF, 6);
    drive(1'b0, 1'b0, 4'hF, 2);
    // Skip from ptr 2 to destination 1, then wrap to destination 3.
    drive(1'b0, 1'b1, 4'b0010, 1);
    drive(1'b0, 1'b0, 4'b0010, 2);
    drive(1'b0, 1'b1, 4'b1001, 1);
    drive(1'b0, 1'b0, 4'b1001, 2);
    // Backpressure with a second token held upstream.
    drive(1'b0, 1'b1, 4'b0000, 1);
    drive(1'b0, 1'b1, 4'b0000, 5);
    drive(1'b0, 1'b1, 4'b0100, 1);
    drive(1'b0, 1'b0, 4'b0100, 2);
    // Long wait to exercise the stall flag.
    drive(1'b0, 1'b1, 4'b0000, 1);
    drive(1'b0, 1'b0, 4'b0000, 8);
    drive(1'b0, 1'b0, 4'b1000, 2);
    // Reset while a token is pending.
    drive(1'b0, 1'b1, 4'b0000, 1);
    drive(1'b0, 1'b0, 4'b0000, 2);
    drive(1'b1, 1'b0, 4'b0000, 1);
    drive(1'b0, 1'b0, 4'hF, 4);
    // Randomized traffic with occasional resets and idle destinations.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
            1);
    end
    drive(1'b0, 1'b0, 4'hF, 3);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
